// File: rtl/wb_pkg.sv
// Shared types and helpers for the result-matrix writeback controller.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int total_elems(input int rows, input int cols);
        return rows * cols;
    endfunction

endpackage

// File: rtl/writeback_controller_counter.sv
// Wrapping up-counter with synchronous clear; co pulses when an enabled
// count steps past MAX, so counters can be chained.
module Counter #(
    parameter int WIDTH = 2,
    parameter int MAX   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             co
);

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MAX);

    assign co = en && (count == TOP);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= co ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/writeback_controller.sv
// Drains the ROW x COL result FIFOs into RAM in row-major order, one write
// per element starting at BASE_ADDR, then pulses wb_done.
module writeback_controller
    import wb_pkg::*;
#(
    parameter int ADD_WIDTH = 6,
    parameter int ROW       = 4,
    parameter int COL       = 4,
    parameter int BASE_ADDR = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ROW-1:0]         res_empty,
    output logic [ROW-1:0]         read_fifo,
    output logic [$clog2(ROW)-1:0] sel,
    output logic [ADD_WIDTH:0]     add_w,
    output logic                   w_en,
    output logic                   busy,
    output logic                   wb_done
);

    localparam int RW = $clog2(ROW);
    localparam int CW = $clog2(COL);
    localparam logic [ADD_WIDTH:0] BASE  = BASE_ADDR[ADD_WIDTH:0];
    localparam logic [ADD_WIDTH:0] COL_A = COL[ADD_WIDTH:0];

    state_t             state;
    state_t             state_next;
    logic [RW-1:0]      r;
    logic [CW-1:0]      c;
    logic               fire;
    logic               clr;
    logic               col_co;
    logic               row_co;
    logic [ADD_WIDTH:0] addr_next;

    assign fire = (state == READ) && !res_empty[r];
    assign clr  = (state == IDLE) && start;

    Counter #(
        .WIDTH (CW),
        .MAX   (COL - 1)
    ) col_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (fire),
        .count (c),
        .co    (col_co)
    );

    // The row counter's carry marks the fire on the very last element.
    Counter #(
        .WIDTH (RW),
        .MAX   (ROW - 1)
    ) row_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (col_co),
        .count (r),
        .co    (row_co)
    );

    assign addr_next = BASE + (ADD_WIDTH+1)'(r) * COL_A + (ADD_WIDTH+1)'(c);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        read_fifo  = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (fire) begin
                    read_fifo = ROW'(1) << r;
                end
                if (row_co) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy    = (state != IDLE);
    assign wb_done = (state == DONE);

    // FIFO data lands one cycle after the strobe, so the write side trails by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_en  <= 1'b0;
            sel   <= '0;
            add_w <= '0;
        end else begin
            w_en <= fire;
            if (fire) begin
                sel   <= r;
                add_w <= addr_next;
            end
        end
    end

endmodule

// File: tb/tb_writeback_controller.sv
// Scoreboard bench for writeback_controller: a 4x4 instance for most
// scenarios plus a 2x8 instance at BASE_ADDR=64 for the parameter sweep.
module tb_writeback_controller;

    typedef struct {
        logic [6:0] addr;
        logic [1:0] sel;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic [3:0] res_empty;
    logic [3:0] read_fifo;
    logic [1:0] sel;
    logic [6:0] add_w;
    logic       w_en;
    logic       busy;
    logic       wb_done;
    logic [1:0] res_empty2;
    logic [1:0] read_fifo2;
    logic [0:0] sel2;
    logic [6:0] add_w2;
    logic       w_en2;
    logic       busy2;
    logic       wb_done2;

    int  vectors     = 0;
    int  miscompares = 0;
    wr_t sb[$];

    always #5 clk = ~clk;

    writeback_controller #(
        .ADD_WIDTH (6), .ROW (4), .COL (4), .BASE_ADDR (32)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .res_empty (res_empty),
        .read_fifo (read_fifo), .sel (sel), .add_w (add_w), .w_en (w_en),
        .busy (busy), .wb_done (wb_done)
    );

    writeback_controller #(
        .ADD_WIDTH (6), .ROW (2), .COL (8), .BASE_ADDR (64)
    ) dut2 (
        .clk (clk), .rst (rst), .start (start2), .res_empty (res_empty2),
        .read_fifo (read_fifo2), .sel (sel2), .add_w (add_w2), .w_en (w_en2),
        .busy (busy2), .wb_done (wb_done2)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task push_drain(input int base, input int cols, input int total);
        for (int i = 0; i < total; i++) begin
            sb.push_back('{addr: 7'(base + i), sel: 2'(i / cols)});
        end
    endtask

    task test_reset;
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        res_empty = '0; res_empty2 = '0;
        tick; tick;
        vectors++;
        if ({read_fifo, sel, add_w, w_en, busy, wb_done} !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs rf=%b sel=%0d add_w=%0d w_en=%b busy=%b done=%b (want all 0)",
                     read_fifo, sel, add_w, w_en, busy, wb_done);
        end
        vectors++;
        if ({read_fifo2, sel2, add_w2, w_en2, busy2, wb_done2} !== 14'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs2 rf=%b sel=%0d add_w=%0d w_en=%b busy=%b done=%b (want all 0)",
                     read_fifo2, sel2, add_w2, w_en2, busy2, wb_done2);
        end
        rst = 1'b0;
        for (int n = 0; n < 10; n++) begin
            tick;
            vectors++;
            if (read_fifo !== 4'b0 || w_en !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL idle_quiet cyc=%0d rf=%b w_en=%b busy=%b (want 0,0,0)",
                         n, read_fifo, w_en, busy);
            end
        end
    endtask

    task test_full_drain;
        wr_t e;
        logic [3:0] exp_rf;
        push_drain(32, 4, 16);
        start = 1'b1; tick; start = 1'b0;
        for (int n = 1; n <= 22; n++) begin
            exp_rf = (n <= 16) ? 4'(1 << ((n - 1) / 4)) : 4'b0;
            vectors++;
            if (read_fifo !== exp_rf) begin
                miscompares++;
                $display("[TB] FAIL drain_read_fifo cyc=%0d got=%b want=%b", n, read_fifo, exp_rf);
            end
            vectors++;
            if (w_en !== (n >= 2 && n <= 17) || wb_done !== (n == 18) || busy !== (n <= 18)) begin
                miscompares++;
                $display("[TB] FAIL drain_ctrl cyc=%0d w_en=%b done=%b busy=%b want %b %b %b", n,
                         w_en, wb_done, busy, (n >= 2 && n <= 17), (n == 18), (n <= 18));
            end
            if (w_en === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (add_w !== e.addr || sel !== e.sel) begin
                    miscompares++;
                    $display("[TB] FAIL drain_write cyc=%0d add_w=%0d sel=%0d want add_w=%0d sel=%0d",
                             n, add_w, sel, e.addr, e.sel);
                end
            end
            tick;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain_count leftover=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task test_stall;
        wr_t e;
        int reads;
        logic prev_fire;
        logic exp_fire;
        logic [3:0] exp_rf;
        reads = 0; prev_fire = 1'b0;
        push_drain(32, 4, 16);
        start = 1'b1; tick; start = 1'b0;
        for (int n = 1; n <= 26; n++) begin
            // FIFO 3 empty while row 0 drains must be ignored.
            res_empty = {n <= 4, 1'b0, (n >= 7 && n <= 9), 1'b0};
            #1;
            exp_fire = (reads < 16) && !(n >= 7 && n <= 9);
            exp_rf   = exp_fire ? 4'(1 << (reads / 4)) : 4'b0;
            vectors++;
            if (read_fifo !== exp_rf) begin
                miscompares++;
                $display("[TB] FAIL stall_read_fifo cyc=%0d got=%b want=%b", n, read_fifo, exp_rf);
            end
            vectors++;
            if (w_en !== prev_fire || wb_done !== (n == 21)) begin
                miscompares++;
                $display("[TB] FAIL stall_ctrl cyc=%0d w_en=%b done=%b want %b %b",
                         n, w_en, wb_done, prev_fire, (n == 21));
            end
            if (w_en === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (add_w !== e.addr || sel !== e.sel) begin
                    miscompares++;
                    $display("[TB] FAIL stall_write cyc=%0d add_w=%0d sel=%0d want add_w=%0d sel=%0d",
                             n, add_w, sel, e.addr, e.sel);
                end
            end
            prev_fire = exp_fire;
            if (exp_fire) reads++;
            tick;
        end
        res_empty = '0;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL stall_count leftover=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task test_start_while_busy;
        wr_t e;
        int writes;
        int dones;
        writes = 0; dones = 0;
        push_drain(32, 4, 16);
        start = 1'b1; tick; start = 1'b0;
        for (int n = 1; n <= 28; n++) begin
            start = (n == 5 || n == 18);
            if (wb_done === 1'b1) dones++;
            if (w_en === 1'b1) begin
                writes++;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    vectors++;
                    if (add_w !== e.addr) begin
                        miscompares++;
                        $display("[TB] FAIL busy_write cyc=%0d add_w=%0d want %0d", n, add_w, e.addr);
                    end
                end
            end
            if (n >= 20) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL busy_restart cyc=%0d busy=%b want 0", n, busy);
                end
            end
            tick;
        end
        start = 1'b0;
        vectors++;
        if (writes != 16 || dones != 1) begin
            miscompares++;
            $display("[TB] FAIL busy_totals writes=%0d dones=%0d want 16 1", writes, dones);
        end
        sb.delete();
    endtask

    task test_back_to_back;
        wr_t e;
        logic exp_wen;
        push_drain(32, 4, 16);
        push_drain(32, 4, 16);
        start = 1'b1; tick; start = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            start   = (n == 18 || n == 19);
            exp_wen = (n >= 2 && n <= 17) || (n >= 21 && n <= 36);
            vectors++;
            if (w_en !== exp_wen || wb_done !== (n == 18 || n == 37)) begin
                miscompares++;
                $display("[TB] FAIL b2b_ctrl cyc=%0d w_en=%b done=%b want %b %b",
                         n, w_en, wb_done, exp_wen, (n == 18 || n == 37));
            end
            if (w_en === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (add_w !== e.addr || sel !== e.sel) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_write cyc=%0d add_w=%0d sel=%0d want add_w=%0d sel=%0d",
                             n, add_w, sel, e.addr, e.sel);
                end
            end
            tick;
        end
        start = 1'b0;
        vectors++;
        if (sb.size() != 0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_end leftover=%0d busy=%b want 0 0", sb.size(), busy);
            sb.delete();
        end
    endtask

    task test_reset_mid_drain;
        wr_t e;
        start = 1'b1; tick; start = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            rst = (n == 9);
            tick;
        end
        rst = 1'b0;
        vectors++;
        if (w_en !== 1'b0 || busy !== 1'b0 || read_fifo !== 4'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_state w_en=%b busy=%b rf=%b want 0 0 0", w_en, busy, read_fifo);
        end
        push_drain(32, 4, 16);
        start = 1'b1; tick; start = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            vectors++;
            if (wb_done !== (n == 18)) begin
                miscompares++;
                $display("[TB] FAIL midreset_done cyc=%0d got=%b want=%b", n, wb_done, (n == 18));
            end
            if (w_en === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (add_w !== e.addr || sel !== e.sel) begin
                    miscompares++;
                    $display("[TB] FAIL midreset_write cyc=%0d add_w=%0d sel=%0d want add_w=%0d sel=%0d",
                             n, add_w, sel, e.addr, e.sel);
                end
            end
            tick;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_count leftover=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task test_param_sweep;
        wr_t e;
        logic [1:0] exp_rf;
        push_drain(64, 8, 16);
        start2 = 1'b1; tick; start2 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            exp_rf = (n <= 16) ? 2'(1 << ((n - 1) / 8)) : 2'b0;
            vectors++;
            if (read_fifo2 !== exp_rf || w_en2 !== (n >= 2 && n <= 17) || wb_done2 !== (n == 18)) begin
                miscompares++;
                $display("[TB] FAIL sweep_ctrl cyc=%0d rf=%b w_en=%b done=%b want %b %b %b", n,
                         read_fifo2, w_en2, wb_done2, exp_rf, (n >= 2 && n <= 17), (n == 18));
            end
            if (w_en2 === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (add_w2 !== e.addr || sel2[0] !== e.sel[0]) begin
                    miscompares++;
                    $display("[TB] FAIL sweep_write cyc=%0d add_w=%0d sel=%0d want add_w=%0d sel=%0d",
                             n, add_w2, sel2, e.addr, e.sel[0]);
                end
            end
            tick;
        end
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sweep_count leftover=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        test_reset;
        test_full_drain;
        test_stall;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_drain;
        test_param_sweep;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
